// File: rtl/fp32_quant_pkg.sv
// Shared constants and stage records for the fp32 -> int8 quantize/pack path.
package fp32_quant_pkg;

    localparam int FP32_EXP_BIAS = 127;

    localparam logic [1:0] RM_RNE = 2'b00;
    localparam logic [1:0] RM_RTZ = 2'b01;
    localparam logic [1:0] RM_RUP = 2'b10;
    localparam logic [1:0] RM_RDN = 2'b11;

    localparam int INT8_MAX = 127;
    localparam int INT8_MIN = -128;

    // S1: sample after ReLU and subnormal flush, with its per-sample controls
    typedef struct packed {
        logic        vld;
        logic        flush;
        logic [31:0] x;
        logic [7:0]  shift;
        logic [1:0]  rm;
    } s1_t;

    // S2: rounded/clamped lane value
    typedef struct packed {
        logic       vld;
        logic       flush;
        logic [7:0] q;
        logic       sat;
    } s2_t;

endpackage

// File: rtl/fp32_to_int_round.sv
// fp32 * 2^shift -> saturating int8 with selectable rounding; combinational.
// Inputs are expected to be subnormal-flushed already (exp==0 means zero).
module fp32_to_int_round
    import fp32_quant_pkg::*;
(
    input  logic [31:0] fp32,
    input  logic [7:0]  shift,
    input  logic [1:0]  rm,
    output logic [7:0]  q,
    output logic        sat
);

    logic              sign;
    logic [7:0]        exp;
    logic [22:0]       man;
    logic signed [9:0] e_unb;
    logic [3:0]        sh2;
    logic [31:0]       ext;
    logic [7:0]        mag;
    logic              g;
    logic              st;
    logic              inc;
    logic [8:0]        mag_r;

    assign sign  = fp32[31];
    assign exp   = fp32[30:23];
    assign man   = fp32[22:0];
    assign e_unb = $signed({2'b00, exp}) - $signed(10'(FP32_EXP_BIAS))
                 + $signed({{2{shift[7]}}, shift});

    // Magnitudes >= 256 (e_unb > 7) saturate before rounding. Below that the
    // significand sits at bits [31:8] of ext, so after the right shift the
    // integer part is ext[31:24], guard ext[23], sticky the rest.
    always_comb begin
        q     = '0;
        sat   = 1'b0;
        sh2   = 4'd9;
        ext   = '0;
        mag   = '0;
        g     = 1'b0;
        st    = 1'b0;
        inc   = 1'b0;
        mag_r = '0;
        if (exp == 8'hFF) begin
            sat = 1'b1;
            q   = (man != 23'd0) ? 8'h00 : (sign ? 8'(INT8_MIN) : 8'(INT8_MAX));
        end else if (exp == 8'h00) begin
            q = '0;
        end else if (e_unb > 10'sd7) begin
            sat = 1'b1;
            q   = sign ? 8'(INT8_MIN) : 8'(INT8_MAX);
        end else begin
            // below 2^-2 everything lands in sticky; shift 9 keeps it nonzero
            if (e_unb >= -10'sd2)
                sh2 = 4'(10'sd7 - e_unb);
            ext = {1'b1, man, 8'b0} >> sh2;
            mag = ext[31:24];
            g   = ext[23];
            st  = |ext[22:0];
            case (rm)
                RM_RNE:  inc = g & (st | mag[0]);
                RM_RTZ:  inc = 1'b0;
                RM_RUP:  inc = (g | st) & ~sign;
                default: inc = (g | st) & sign;
            endcase
            mag_r = {1'b0, mag} + 9'(inc);
            if (sign && mag_r > 9'(-INT8_MIN)) begin
                sat = 1'b1;
                q   = 8'(INT8_MIN);
            end else if (!sign && mag_r > 9'(INT8_MAX)) begin
                sat = 1'b1;
                q   = 8'(INT8_MAX);
            end else begin
                q = sign ? 8'(~mag_r + 9'd1) : mag_r[7:0];
            end
        end
    end

endmodule

// File: rtl/fp32_relu_quant_pack.sv
// ReLU + int8 quantize of an fp32 stream, packed LANES per word; q_valid 3 cycles
// after the completing sample. No backpressure: one sample accepted every cycle.
module fp32_relu_quant_pack
    import fp32_quant_pkg::*;
#(
    parameter int LANES    = 4,
    parameter int OUT_BITS = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      x_valid,
    input  logic [31:0]               x,
    input  logic                      relu_en,
    input  logic [7:0]                shift,
    input  logic [1:0]                rm,
    input  logic                      flush,
    output logic [LANES*OUT_BITS-1:0] q_data,
    output logic                      q_valid,
    output logic [2:0]                q_lanes,
    output logic                      q_sat
);

    localparam int CW = $clog2(LANES);

    s1_t         s1;
    s2_t         s2;
    logic [31:0] x_dec;
    logic [7:0]  conv_q;
    logic        conv_sat;

    logic [LANES-1:0][OUT_BITS-1:0] lane_q;
    logic [LANES-1:0][OUT_BITS-1:0] lane_nxt;
    logic [LANES-1:0]               lsat_q;
    logic [LANES-1:0]               lsat_nxt;
    logic [CW-1:0]                  cnt;
    logic [CW:0]                    cnt_eff;
    logic                           emit;

    // ReLU wins over everything (including -Inf/-NaN); subnormals keep sign only
    always_comb begin
        x_dec = x;
        if (relu_en && x[31])
            x_dec = '0;
        else if (x[30:23] == 8'h00)
            x_dec = {x[31], 31'b0};
    end

    always_ff @(posedge clk) begin
        if (rst)
            s1 <= '0;
        else
            s1 <= '{vld: x_valid, flush: flush, x: x_dec, shift: shift, rm: rm};
    end

    fp32_to_int_round u_round (
        .fp32  (s1.x),
        .shift (s1.shift),
        .rm    (s1.rm),
        .q     (conv_q),
        .sat   (conv_sat)
    );

    always_ff @(posedge clk) begin
        if (rst)
            s2 <= '0;
        else
            s2 <= '{vld: s1.vld, flush: s1.flush, q: conv_q, sat: conv_sat};
    end

    always_comb begin
        lane_nxt = lane_q;
        lsat_nxt = lsat_q;
        if (s2.vld) begin
            lane_nxt[cnt] = s2.q;
            lsat_nxt[cnt] = s2.sat;
        end
        cnt_eff = {1'b0, cnt} + (CW+1)'(s2.vld);
        emit    = (s2.vld && cnt == CW'(LANES-1)) || (s2.flush && cnt_eff != '0);
    end

    // Lanes are zeroed after each emit so a partial word carries zeros above q_lanes
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            lane_q  <= '0;
            lsat_q  <= '0;
            q_data  <= '0;
            q_valid <= 1'b0;
            q_lanes <= '0;
            q_sat   <= 1'b0;
        end else if (emit) begin
            q_data  <= lane_nxt;
            q_lanes <= 3'(cnt_eff);
            q_sat   <= |lsat_nxt;
            q_valid <= 1'b1;
            lane_q  <= '0;
            lsat_q  <= '0;
            cnt     <= '0;
        end else begin
            q_valid <= 1'b0;
            lane_q  <= lane_nxt;
            lsat_q  <= lsat_nxt;
            cnt     <= cnt_eff[CW-1:0];
        end
    end

endmodule

// File: tb/tb_fp32_relu_quant_pack.sv
// Scoreboard bench: expected words built from a real-number model at drive time.
module tb_fp32_relu_quant_pack;

    logic        clk = 1'b0;
    logic        rst;
    logic        x_valid;
    logic [31:0] x;
    logic        relu_en;
    logic [7:0]  shift;
    logic [1:0]  rm;
    logic        flush;
    logic [31:0] q_data;
    logic        q_valid;
    logic [2:0]  q_lanes;
    logic        q_sat;

    always #5 clk = ~clk;

    fp32_relu_quant_pack #(.LANES(4), .OUT_BITS(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .x_valid (x_valid),
        .x       (x),
        .relu_en (relu_en),
        .shift   (shift),
        .rm      (rm),
        .flush   (flush),
        .q_data  (q_data),
        .q_valid (q_valid),
        .q_lanes (q_lanes),
        .q_sat   (q_sat)
    );

    typedef struct {
        logic [31:0] dat;
        logic [2:0]  lanes;
        logic        sat;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic [31:0] m_dat = '0;
    int          m_cnt = 0;
    logic        m_sat = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic void model(input logic [31:0] xv, input logic re, input logic [7:0] sh,
                                  input logic [1:0] r, output logic [7:0] q, output logic s);
        int  e;
        int  fi;
        real v;
        real fl;
        real fr;
        real rr;
        q = 8'h00;
        s = 1'b0;
        if (re && xv[31]) return;
        if (xv[30:23] == 8'hFF) begin
            s = 1'b1;
            if (xv[22:0] == 23'd0) q = xv[31] ? 8'h80 : 8'h7F;
            return;
        end
        if (xv[30:23] == 8'h00) return;
        e = int'(xv[30:23]) - 127 + int'($signed(sh));
        v = 1.0 + real'(xv[22:0]) / 8388608.0;
        if (e >= 0) repeat (e) v = v * 2.0;
        else repeat (-e) v = v / 2.0;
        if (xv[31]) v = -v;
        if (v >= 256.0) begin q = 8'h7F; s = 1'b1; return; end
        if (v <= -257.0) begin q = 8'h80; s = 1'b1; return; end
        fl = $floor(v);
        fr = v - fl;
        case (r)
            2'b00: begin
                fi = int'(fl);
                if (fr > 0.5 || (fr == 0.5 && (fi & 1) == 1)) rr = fl + 1.0;
                else rr = fl;
            end
            2'b01:   rr = (v >= 0.0) ? fl : $ceil(v);
            2'b10:   rr = $ceil(v);
            default: rr = fl;
        endcase
        fi = int'(rr);
        if (fi > 127) begin fi = 127; s = 1'b1; end
        if (fi < -128) begin fi = -128; s = 1'b1; end
        q = 8'(fi);
    endfunction

    task automatic drive(input logic [31:0] xv, input logic re, input logic [7:0] sh,
                         input logic [1:0] r, input logic v, input logic fl);
        logic [7:0] q;
        logic       s;
        @(posedge clk);
        #1;
        x_valid = v;
        x       = xv;
        relu_en = re;
        shift   = sh;
        rm      = r;
        flush   = fl;
        if (v) begin
            model(xv, re, sh, r, q, s);
            m_dat[8*m_cnt +: 8] = q;
            m_sat = m_sat | s;
            m_cnt++;
        end
        if (m_cnt == 4 || (fl && m_cnt > 0)) begin
            sb.push_back('{m_dat, 3'(m_cnt), m_sat, cyc + 3});
            m_dat = '0;
            m_cnt = 0;
            m_sat = 1'b0;
        end
    endtask

    task automatic smp(input logic [31:0] xv, input logic [7:0] sh, input logic [1:0] r, input logic re);
        drive(xv, re, sh, r, 1'b1, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(32'h0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && q_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_q_valid", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("q_data", q_data, e.dat);
                chk("q_lanes", 32'(q_lanes), 32'(e.lanes));
                chk("q_sat", 32'(q_sat), 32'(e.sat));
                chk("latency", cyc, e.cyc);
            end
        end
    end

    initial begin
        rst = 1'b1; x_valid = 1'b0; x = '0; relu_en = 1'b0;
        shift = '0; rm = '0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_q_data", q_data, 32'h0);
        chk("rst_q_valid", 32'(q_valid), 32'h0);
        chk("rst_q_lanes", 32'(q_lanes), 32'h0);
        chk("rst_q_sat", 32'(q_sat), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 1,2,3,4 -> 0x04030201
        smp(32'h3F800000, 8'h00, 2'b00, 1'b0);
        smp(32'h40000000, 8'h00, 2'b00, 1'b0);
        smp(32'h40400000, 8'h00, 2'b00, 1'b0);
        smp(32'h40800000, 8'h00, 2'b00, 1'b0);
        // rounding and ReLU on +-2.5
        smp(32'h40200000, 8'h00, 2'b00, 1'b0);
        smp(32'h40200000, 8'h00, 2'b10, 1'b0);
        smp(32'hC0200000, 8'h00, 2'b00, 1'b0);
        smp(32'hC0200000, 8'h00, 2'b00, 1'b1);
        // saturation / specials, then shift scaling
        smp(32'h43960000, 8'h00, 2'b00, 1'b0);
        smp(32'hFF800000, 8'h00, 2'b00, 1'b0);
        smp(32'h7FC00000, 8'h00, 2'b00, 1'b0);
        smp(32'h3FC00000, 8'h03, 2'b00, 1'b0);
        // 0.75 rounds to 1, flushed alone as a one-lane word
        drive(32'h3FC00000, 1'b0, 8'hFF, 2'b00, 1'b1, 1'b1);
        // two samples then flush; a second flush with nothing pending
        smp(32'h3F800000, 8'h00, 2'b00, 1'b0);
        smp(32'h40000000, 8'h00, 2'b00, 1'b0);
        drive(32'h0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b1);
        idle(2);
        drive(32'h0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b1);
        idle(5);
        // flush arriving with the fourth sample yields a single word
        smp(32'h40A00000, 8'h00, 2'b01, 1'b0);
        smp(32'hBFC00000, 8'h00, 2'b11, 1'b0);
        smp(32'h80000001, 8'h00, 2'b00, 1'b0);
        drive(32'h3F000000, 1'b0, 8'h00, 2'b10, 1'b1, 1'b1);
        idle(4);

        for (int i = 0; i < 60; i++) begin
            logic [31:0] xv;
            logic [7:0]  ex;
            ex = 8'(118 + $urandom_range(0, 17));
            xv = {1'($urandom), ex, 23'($urandom)};
            if (i % 11 == 0) xv[30:23] = 8'h00;
            drive(xv, 1'($urandom), 8'($urandom_range(0, 8) - 4), 2'($urandom),
                  1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 6) == 0));
        end
        drive(32'h0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b1);
        idle(5);

        // reset mid-word: three in-flight samples must vanish
        smp(32'h3F800000, 8'h00, 2'b00, 1'b0);
        smp(32'h40000000, 8'h00, 2'b00, 1'b0);
        smp(32'h40400000, 8'h00, 2'b00, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1; x_valid = 1'b0; flush = 1'b0;
        m_dat = '0; m_cnt = 0; m_sat = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) smp(32'h40A00000, 8'h00, 2'b00, 1'b0);
        idle(1);

        for (int i = 0; i < 20 && sb.size() > 0; i++) idle(1);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fp32_relu_quant_pack.md
FP32_RELU_QUANT_PACK -- requirements
Module: fp32_relu_quant_pack

Interface
REQ-001 SHALL have parameter LANES, default 4, meaning int8 lanes packed per output word (fixed 4 in this revision).
REQ-002 SHALL have parameter OUT_BITS, default 8, meaning signed integer width per lane.
REQ-003 SHALL have port clk  input  1  rising-edge clock; the only clock.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port x_valid  input  1  sample strobe, driven from fp32_batchnorm y_valid.
REQ-006 SHALL have port x  input  32  IEEE-754 fp32 sample, driven from fp32_batchnorm y.
REQ-007 SHALL have port relu_en  input  1  1 = clamp negative samples to zero before quantization.
REQ-008 SHALL have port shift  input  8  signed two's-complement scale exponent; quantized value = x * 2^shift.
REQ-009 SHALL have port rm  input  2  rounding mode: 00 nearest-even, 01 toward zero, 10 toward +inf, 11 toward -inf.
REQ-010 SHALL have port flush  input  1  emit any partially filled word.
REQ-011 SHALL have port q_data  output  32  packed word, lane k in bits [8k+7:8k].
REQ-012 SHALL have port q_valid  output  1  one-cycle pulse qualifying q_data, q_lanes, q_sat.
REQ-013 SHALL have port q_lanes  output  3  number of valid lanes in q_data (1..4).
REQ-014 SHALL have port q_sat  output  1  1 = at least one lane in the word saturated or came from Inf/NaN.

Function
REQ-015 SHALL sample x, relu_en, shift, rm together on a cycle with x_valid=1; no backpressure, one sample accepted per cycle.
REQ-016 SHALL pipeline as: S1 decode/ReLU register, S2 round/clamp register, S3 pack register; lane written 2 cycles after x_valid, q_valid asserted 3 cycles after x_valid of the completing sample.
REQ-017 SHALL, when relu_en=1 and sign=1 (including -0, -Inf), force the sample to +0 with no saturation flag.
REQ-018 SHALL flush subnormal inputs to zero (sign kept) before rounding.
REQ-019 SHALL round the exact value (-1)^s * 1.m * 2^(e-127+shift) to an integer per rm using guard and sticky bits over the full mantissa.
REQ-020 SHALL clamp the rounded integer to [-128, 127]; lane sat flag set if clamping changed the value.
REQ-021 SHALL map +Inf to 127, -Inf to -128, NaN to 0, each with lane sat flag set.
REQ-022 SHALL keep a lane counter 0..3; each converted sample writes lane[counter] and increments it.
REQ-023 SHALL, when the fourth lane is written, assert q_valid for one cycle with q_lanes=4, OR of four lane sat flags on q_sat, and reset counter to 0.
REQ-024 SHALL carry flush through S1/S2 alongside data; when it reaches S3 with counter>0 (counting a sample arriving the same cycle), emit the partial word with unused lanes zero and q_lanes=counter, then reset counter.
REQ-025 SHALL ignore a flush that reaches S3 with no pending lanes (no q_valid).
REQ-026 SHALL, if flush arrives with the fourth sample, emit exactly one word (q_lanes=4).
REQ-027 SHALL hold q_data, q_lanes, q_sat stable between pulses; q_valid low otherwise.

Reset
REQ-028 SHALL on rst=1 clear S1/S2 valid and flush bits, lane counter, lane sat flags, and drive q_data=0, q_valid=0, q_lanes=0, q_sat=0 at the next edge.
REQ-029 SHALL discard a partially filled word and in-flight samples on reset mid-operation; first word after reset starts at lane 0.

Structure
REQ-030 SHALL place FP32_EXP_BIAS=127, rounding-mode encodings (RM_RNE=00, RM_RTZ=01, RM_RUP=10, RM_RDN=11, same encoding as fp32_batchnorm rm), INT8_MAX/INT8_MIN in shared package fp32_quant_pkg.
REQ-031 SHALL implement S2 arithmetic in one sub-module fp32_to_int_round (fp32, shift, rm in; int8, sat out; combinational).

Verification
REQ-032 Four x_valid samples 1.0,2.0,3.0,4.0 (0x3F800000..0x40800000), shift=0, rm=00 -> q_data=0x04030201, q_lanes=4, q_sat=0, q_valid 3 cycles after 4th sample.
REQ-033 x=2.5 (0x40200000): rm=00 -> lane 0x02; rm=10 -> 0x03; x=-2.5 (0xC0200000), relu_en=0, rm=00 -> 0xFE; relu_en=1 -> 0x00.
REQ-034 x=300.0 (0x43960000) -> 0x7F, q_sat=1; x=-Inf (0xFF800000) relu_en=0 -> 0x80, q_sat=1; NaN (0x7FC00000) -> 0x00, q_sat=1.
REQ-035 x=1.5 (0x3FC00000), shift=3 -> 0x0C; shift=-1, rm=00 -> 0x01 (0.75 rounds up).
REQ-036 Two samples 1.0, 2.0 then flush -> q_data=0x00000201, q_lanes=2; second flush with nothing pending -> no q_valid.
REQ-037 Three samples then rst=1 for one cycle, then four samples 5.0 -> q_data=0x05050505, no stale lanes.
